conv_operand_loader: RTL and testbench

Upstream operand stage for the single-PE 3x3 convolution engine. Accepts a byte stream over a valid/ready handshake, assembles the 3x3 filter (b11..b33) and the 4x4 activation tile (a11..a44) into holding registers, then asserts active_single and holds all operands stable until the engine reports done_single. Supports filter reuse across tiles, and detects framing errors and engine timeouts.

---
 rtl/conv_operand_loader_if.sv | 49 ++++
 rtl/conv_operand_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_conv_operand_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_operand_loader_if.sv
// Stream, operand and engine-control bundle for the 3x3 convolution operand loader.
// Latency: none (wires only).
// Backpressure: in_ready is driven by the loader; the stream side holds bytes while in_ready=0.
//
// Port summary:
//   stream : in_valid, in_data[7:0], in_last, keep_filter  -> loader ; in_ready <- loader
//   tile   : a11..a44 (8 bit each, row-major)              <- loader
//   filter : b11..b33 (8 bit each, row-major)              <- loader
//   engine : active_single, frame_done, err[1:0] <- loader ; done_single, clr_err -> loader
interface conv_operand_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       keep_filter;
    logic       in_ready;

    logic [7:0] a11, a12, a13, a14;
    logic [7:0] a21, a22, a23, a24;
    logic [7:0] a31, a32, a33, a34;
    logic [7:0] a41, a42, a43, a44;

    logic [7:0] b11, b12, b13;
    logic [7:0] b21, b22, b23;
    logic [7:0] b31, b32, b33;

    logic       active_single;
    logic       done_single;
    logic       frame_done;
    logic [1:0] err;
    logic       clr_err;

    // slave: the loader itself
    modport slave (
        input  in_valid, in_data, in_last, keep_filter, done_single, clr_err,
        output in_ready, active_single, frame_done, err,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33
    );

    // master: byte source plus convolution engine
    modport master (
        output in_valid, in_data, in_last, keep_filter, done_single, clr_err,
        input  in_ready, active_single, frame_done, err,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33
    );
endinterface

// File: rtl/conv_operand_loader.sv
// Assembles a 3x3 filter and 4x4 activation tile from a byte stream, then holds them for the PE.
// Latency: operands valid and active_single high the cycle after the last beat; frame_done one cycle after done_single.
// Backpressure: in_ready=1 in every load/drain state (one byte per cycle), 0 while the engine runs.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears operands, errors and the filter-valid flag)
//   bus          conv_operand_loader_if.slave: stream in, operands out, engine handshake, sticky err
// Parameter RUN_TIMEOUT: max RUN cycles without done_single before the run is abandoned (err[1]).
module conv_operand_loader #(
    parameter int RUN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_operand_loader_if.slave  bus
);

    localparam int            TW   = (RUN_TIMEOUT > 2) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_A,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    idx;
    logic [3:0]    idx_nxt;
    logic          filter_ok;
    logic [7:0]    a_q [16];
    logic [7:0]    b_q [9];
    logic [TW-1:0] tcnt;
    logic [1:0]    err_q;
    logic          frame_done_q;

    // Moore outputs decoded from the registered state only.
    logic          ready_int;
    logic          beat;

    // Per-cycle actions produced by the next-state logic.
    logic          wr_a;
    logic          wr_b;
    logic [3:0]    wr_idx;
    logic          set_fok;
    logic          clr_fok;
    logic          err_frm;
    logic          err_to;
    logic          done_pulse;

    assign ready_int = (state != RUN);
    assign beat      = bus.in_valid && ready_int;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        wr_idx     = idx;
        set_fok    = 1'b0;
        clr_fok    = 1'b0;
        err_frm    = 1'b0;
        err_to     = 1'b0;
        done_pulse = 1'b0;

        unique case (state)
            IDLE: begin
                if (beat) begin
                    wr_idx  = 4'd0;
                    idx_nxt = 4'd1;
                    // keep_filter only counts when a complete filter is already held.
                    if (bus.keep_filter && filter_ok) begin
                        wr_a = 1'b1;
                        if (bus.in_last) begin
                            err_frm = 1'b1;
                            idx_nxt = 4'd0;
                        end else begin
                            state_nxt = LOAD_A;
                        end
                    end else begin
                        // b11 is being overwritten, so a one-byte frame leaves the filter broken.
                        wr_b = 1'b1;
                        if (bus.in_last) begin
                            err_frm = 1'b1;
                            clr_fok = 1'b1;
                            idx_nxt = 4'd0;
                        end else begin
                            state_nxt = LOAD_F;
                        end
                    end
                end
            end

            LOAD_F: begin
                if (beat) begin
                    wr_b = 1'b1;
                    if (bus.in_last) begin
                        err_frm   = 1'b1;
                        clr_fok   = 1'b1;
                        idx_nxt   = 4'd0;
                        state_nxt = IDLE;
                    end else if (idx == 4'd8) begin
                        set_fok   = 1'b1;
                        idx_nxt   = 4'd0;
                        state_nxt = LOAD_A;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end

            LOAD_A: begin
                if (beat) begin
                    wr_a = 1'b1;
                    if (idx == 4'd15) begin
                        idx_nxt = 4'd0;
                        if (bus.in_last) begin
                            state_nxt = RUN;
                        end else begin
                            // Frame is too long: swallow the rest up to in_last.
                            err_frm   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (bus.in_last) begin
                        err_frm   = 1'b1;
                        idx_nxt   = 4'd0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end

            RUN: begin
                if (bus.done_single) begin
                    done_pulse = 1'b1;
                    state_nxt  = IDLE;
                end else if (tcnt == TLIM) begin
                    err_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end

            DRAIN: begin
                if (beat && bus.in_last) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand holding registers; no write path exists in RUN because
    // wr_a/wr_b are only raised on beats, and beats need in_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) a_q[i] <= 8'd0;
            for (int i = 0; i < 9; i++)  b_q[i] <= 8'd0;
        end else begin
            if (wr_a) a_q[wr_idx] <= bus.in_data;
            if (wr_b) b_q[wr_idx] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------
    // Filter-valid flag, run timeout, sticky errors, completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_ok    <= 1'b0;
            tcnt         <= '0;
            err_q        <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            if (clr_fok)      filter_ok <= 1'b0;
            else if (set_fok) filter_ok <= 1'b1;

            // Held at zero outside RUN so every run starts counting from zero.
            if (state == RUN) tcnt <= tcnt + TW'(1);
            else              tcnt <= '0;

            // A new error in the clearing cycle still lands.
            err_q <= (bus.clr_err ? 2'b00 : err_q) | {err_to, err_frm};

            frame_done_q <= done_pulse;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready      = ready_int;
    assign bus.active_single = (state == RUN);
    assign bus.frame_done    = frame_done_q;
    assign bus.err           = err_q;

    assign bus.a11 = a_q[0];
    assign bus.a12 = a_q[1];
    assign bus.a13 = a_q[2];
    assign bus.a14 = a_q[3];
    assign bus.a21 = a_q[4];
    assign bus.a22 = a_q[5];
    assign bus.a23 = a_q[6];
    assign bus.a24 = a_q[7];
    assign bus.a31 = a_q[8];
    assign bus.a32 = a_q[9];
    assign bus.a33 = a_q[10];
    assign bus.a34 = a_q[11];
    assign bus.a41 = a_q[12];
    assign bus.a42 = a_q[13];
    assign bus.a43 = a_q[14];
    assign bus.a44 = a_q[15];

    assign bus.b11 = b_q[0];
    assign bus.b12 = b_q[1];
    assign bus.b13 = b_q[2];
    assign bus.b21 = b_q[3];
    assign bus.b22 = b_q[4];
    assign bus.b23 = b_q[5];
    assign bus.b31 = b_q[6];
    assign bus.b32 = b_q[7];
    assign bus.b33 = b_q[8];

endmodule

// File: tb/tb_conv_operand_loader.sv
// Self-checking bench for conv_operand_loader: directed frame sequence with random data,
// random valid gaps and random engine latencies, checked against a frame-level model.
module tb_conv_operand_loader;

    logic clk;
    logic rst;

    conv_operand_loader_if ifc ();

    conv_operand_loader #(.RUN_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // DUT operand view as arrays
    logic [7:0] dut_a [16];
    logic [7:0] dut_b [9];
    assign dut_a[0]  = ifc.a11;  assign dut_a[1]  = ifc.a12;
    assign dut_a[2]  = ifc.a13;  assign dut_a[3]  = ifc.a14;
    assign dut_a[4]  = ifc.a21;  assign dut_a[5]  = ifc.a22;
    assign dut_a[6]  = ifc.a23;  assign dut_a[7]  = ifc.a24;
    assign dut_a[8]  = ifc.a31;  assign dut_a[9]  = ifc.a32;
    assign dut_a[10] = ifc.a33;  assign dut_a[11] = ifc.a34;
    assign dut_a[12] = ifc.a41;  assign dut_a[13] = ifc.a42;
    assign dut_a[14] = ifc.a43;  assign dut_a[15] = ifc.a44;
    assign dut_b[0]  = ifc.b11;  assign dut_b[1]  = ifc.b12;
    assign dut_b[2]  = ifc.b13;  assign dut_b[3]  = ifc.b21;
    assign dut_b[4]  = ifc.b22;  assign dut_b[5]  = ifc.b23;
    assign dut_b[6]  = ifc.b31;  assign dut_b[7]  = ifc.b32;
    assign dut_b[8]  = ifc.b33;

    // Reference model state
    logic [7:0] a_m [16];
    logic [7:0] b_m [9];
    bit         fok_m;
    logic [1:0] err_m;

    logic [7:0] frame_q [$];
    bit         clr_on_last;

    int tests;
    int fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_operands(input string tag);
        for (int i = 0; i < 16; i++) chk({tag, "_a"}, dut_a[i], a_m[i]);
        for (int i = 0; i < 9; i++)  chk({tag, "_b"}, dut_b[i], b_m[i]);
    endtask

    // Frame-level model: the first 9 bytes are filter (unless reuse applies), the next 16
    // activations, anything after is discarded; only in_last on the 16th activation runs.
    task automatic model_apply(input bit keep, output bit run);
        bit skip;
        int nf;
        int p;
        skip = keep && fok_m;
        nf   = skip ? 0 : 9;
        p    = frame_q.size() - 1;
        run  = 1'b0;
        if (clr_on_last) err_m = 2'b00;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i < nf)           b_m[i]      = frame_q[i];
            else if (i < nf + 16) a_m[i - nf] = frame_q[i];
        end
        if (p < nf) begin
            err_m[0] = 1'b1;
            fok_m    = 1'b0;
        end else begin
            if (!skip) fok_m = 1'b1;
            if (p == nf + 15) run = 1'b1;
            else              err_m[0] = 1'b1;
        end
    endtask

    task automatic send_frame(input bit keep, input bit use_last);
        int gaps;
        bit lst;
        for (int i = 0; i < frame_q.size(); i++) begin
            gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                ifc.in_valid = 1'b0;
                step();
            end
            chk("in_ready_load", ifc.in_ready, 1);
            lst = use_last && (i == frame_q.size() - 1);
            ifc.in_valid    = 1'b1;
            ifc.in_data     = frame_q[i];
            ifc.in_last     = lst;
            ifc.keep_filter = keep;
            ifc.clr_err     = clr_on_last && lst;
            step();
        end
        ifc.in_valid    = 1'b0;
        ifc.in_last     = 1'b0;
        ifc.keep_filter = 1'b0;
        ifc.clr_err     = 1'b0;
    endtask

    // Engine: raises done_single during the d-th active cycle (d=0: never).
    // The stream keeps offering bytes during RUN; none may be taken.
    task automatic run_engine(input int d);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (!ifc.active_single) break;
            cnt++;
            chk("frame_done_in_run", ifc.frame_done, 0);
            ifc.in_valid = 1'b1;
            ifc.in_data  = 8'($urandom);
            if (d != 0 && cnt == d) begin
                ifc.done_single = 1'b1;
                step();
                ifc.done_single = 1'b0;
                ifc.in_valid    = 1'b0;
                break;
            end
            step();
            ifc.in_valid = 1'b0;
        end
        ifc.in_valid = 1'b0;
        if (d != 0) begin
            chk("run_len", cnt, d);
            chk("active_after_done", ifc.active_single, 0);
            chk("frame_done_pulse", ifc.frame_done, 1);
            chk("in_ready_after_done", ifc.in_ready, 1);
            step();
            chk("frame_done_single", ifc.frame_done, 0);
        end else begin
            err_m[1] = 1'b1;
            chk("timeout_len", cnt, 64);
            chk("active_after_timeout", ifc.active_single, 0);
            chk("frame_done_timeout", ifc.frame_done, 0);
        end
    endtask

    task automatic do_frame(input string tag, input bit keep, input int d);
        bit run;
        model_apply(keep, run);
        send_frame(keep, 1'b1);
        chk({tag, "_active"}, ifc.active_single, run);
        chk({tag, "_in_ready"}, ifc.in_ready, !run);
        chk({tag, "_err"}, ifc.err, err_m);
        check_operands(tag);
        if (run) begin
            run_engine(d);
            check_operands({tag, "_hold"});
            chk({tag, "_err_end"}, ifc.err, err_m);
        end
    endtask

    task automatic load_seq(input int first, input int n);
        frame_q.delete();
        for (int k = 0; k < n; k++) frame_q.push_back(8'(first + k));
    endtask

    task automatic load_rand(input int n);
        frame_q.delete();
        for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
    endtask

    task automatic clear_errors();
        ifc.clr_err = 1'b1;
        step();
        ifc.clr_err = 1'b0;
        err_m = 2'b00;
        chk("clr_err", ifc.err, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) a_m[i] = 8'd0;
        for (int i = 0; i < 9; i++)  b_m[i] = 8'd0;
        fok_m = 1'b0;
        err_m = 2'b00;
    endtask

    initial begin
        bit kf;
        tests = 0;
        fails = 0;
        clr_on_last     = 1'b0;
        ifc.in_valid    = 1'b0;
        ifc.in_data     = 8'd0;
        ifc.in_last     = 1'b0;
        ifc.keep_filter = 1'b0;
        ifc.done_single = 1'b0;
        ifc.clr_err     = 1'b0;
        model_reset();

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_active", ifc.active_single, 0);
        chk("rst_frame_done", ifc.frame_done, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_in_ready", ifc.in_ready, 1);
        check_operands("rst");

        // keep_filter right after reset is ignored; bytes 1..25, 38-cycle engine
        load_seq(1, 25);
        do_frame("full", 1'b1, 38);

        // Filter reuse: 16 bytes 100..115
        load_seq(100, 16);
        do_frame("reuse", 1'b1, 5);

        // Random mix of full and reuse frames
        for (int n = 0; n < 6; n++) begin
            kf = 1'($urandom_range(0, 1));
            load_rand((kf && fok_m) ? 16 : 25);
            do_frame("rand", kf, $urandom_range(1, 20));
        end

        // in_last on the 5th activation byte, then a good frame
        load_rand(14);
        do_frame("early_a", 1'b0, 1);
        load_rand(25);
        do_frame("after_early", 1'b0, 3);
        clear_errors();

        // in_last inside the filter phase invalidates the stored filter
        load_rand(4);
        do_frame("early_f", 1'b0, 1);
        load_rand(25);
        do_frame("refill", 1'b1, 4);
        clear_errors();

        // Too-long frame: 25 bytes plus 3, in_last on the last
        load_rand(28);
        do_frame("drain", 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("drain_no_run", ifc.active_single, 0);
            chk("drain_in_ready", ifc.in_ready, 1);
        end

        // Error while clr_err is asserted: the new error survives the clear
        clr_on_last = 1'b1;
        load_rand(12);
        do_frame("clr_vs_err", 1'b0, 1);
        clr_on_last = 1'b0;
        clear_errors();

        // Engine never answers
        load_rand(25);
        do_frame("timeout", 1'b0, 0);
        chk("timeout_err", ifc.err, 2'b10);
        clear_errors();

        // Asynchronous reset in the middle of LOAD_A
        load_rand(12);
        send_frame(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_active", ifc.active_single, 0);
        chk("arst_frame_done", ifc.frame_done, 0);
        chk("arst_err", ifc.err, 0);
        check_operands("arst");
        step();
        rst = 1'b0;
        step();
        chk("arst_in_ready", ifc.in_ready, 1);

        // Filter validity was lost: keep_filter must be ignored again
        load_rand(25);
        do_frame("post_rst", 1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
